// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO of pending register-file writes.
// Drains one entry per cycle into the register file write port unless
// rf_hold is high. Optional read forwarding from queued entries is
// compiled in when the macro WBQ_BYPASS_EN is defined; without it the
// register-file read data passes straight through.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [4:0]               push_rd,
    input  logic [31:0]              push_data,
    input  logic                     rf_hold,
    output logic [31:0]              din,
    output logic [4:0]               rd,
    output logic                     writeEnable,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    input  logic [31:0]              rf_regA,
    input  logic [31:0]              rf_regB,
    output logic [31:0]              regA,
    output logic [31:0]              regB,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];

    logic          push_fire;
    logic          pop_fire;

    // Full is judged from the count alone, so a pop in the same cycle never frees a slot early.
    assign push_ready  = (count < CW'(DEPTH));
    assign level       = count;
    // Writes to register 0 are accepted but dropped: they would be architecturally invisible.
    assign push_fire   = push_valid && push_ready && (push_rd != 5'd0);
    // The register file captures din on the same edge that retires the head entry.
    assign writeEnable = (count != '0) && !rf_hold;
    assign pop_fire    = writeEnable;
    assign din         = (count != '0) ? mem_data[head] : 32'd0;
    assign rd          = (count != '0) ? mem_rd[head]   : 5'd0;

    // Pointer and occupancy state; reset empties the queue at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (push_fire) tail <= tail + 1'b1;
            if (pop_fire)  head <= head + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the tail; validity comes only from head/count.
    // NOTE: the storage array is deliberately left without reset; stale slots are never observed.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_rd[tail]   <= push_rd;
            mem_data[tail] <= push_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [AW-1:0] fwd_idx;

    // Forward from the youngest valid entry: scan oldest to youngest so later matches win.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        regA    = rf_regA;
        regB    = rf_regB;
        fwd_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + AW'(i);
            if (CW'(i) < count) begin
                if ((rs != 5'd0) && (mem_rd[fwd_idx] == rs)) regA = mem_data[fwd_idx];
                if ((rt != 5'd0) && (mem_rd[fwd_idx] == rt)) regB = mem_data[fwd_idx];
            end
        end
    end
`else
    logic unused_read_idx;

    // Without forwarding the read indices have no consumer; fold them into a named sink.
    assign unused_read_idx = ^{rs, rt};
    assign regA = rf_regA;
    assign regB = rf_regB;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: a vector table for drain order and
// forwarding, plus hand sequences for full/hold, full-with-pop and reset.
module tb_writeback_queue;

    localparam bit BYP =
`ifdef WBQ_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [4:0]  push_rd;
    logic [31:0] push_data;
    logic        rf_hold;
    logic [31:0] din;
    logic [4:0]  rd;
    logic        writeEnable;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rf_regA;
    logic [31:0] rf_regB;
    logic [31:0] regA;
    logic [31:0] regB;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_rd(push_rd), .push_data(push_data),
        .rf_hold(rf_hold),
        .din(din), .rd(rd), .writeEnable(writeEnable),
        .rs(rs), .rt(rt), .rf_regA(rf_regA), .rf_regB(rf_regB),
        .regA(regA), .regB(regB), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        hold;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_din;
        logic [2:0]  e_level;
        logic        e_ready;
        logic [31:0] e_rega;
        logic [31:0] e_regb;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle_inputs();
        push_valid = 1'b0;
        push_rd    = 5'd0;
        push_data  = 32'd0;
        rs         = 5'd0;
        rt         = 5'd0;
        rf_regA    = 32'd0;
        rf_regB    = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nw;

        //           pv prd  pdata  hold rs  rt  ra       rb       we rd  din   lvl rdy regA                      regB
        vecs[0]  = '{1, 1,  1234, 0,   0,  0,  32'h11,  32'h22,  0, 0,  0,    0,  1,  32'h11,                   32'h22};
        vecs[1]  = '{1, 2,  6666, 0,   2,  1,  32'h1111,32'h2222,1, 1,  1234, 1,  1,  32'h1111,                 BYP ? 32'd1234 : 32'h2222};
        vecs[2]  = '{1, 10, 7777, 0,   2,  0,  32'hAAAA,32'hBBBB,1, 2,  6666, 1,  1,  BYP ? 32'd6666 : 32'hAAAA, 32'hBBBB};
        vecs[3]  = '{1, 11, 2021, 0,   0,  0,  0,       0,       1, 10, 7777, 1,  1,  0,                        0};
        vecs[4]  = '{0, 0,  0,    0,   0,  0,  0,       0,       1, 11, 2021, 1,  1,  0,                        0};
        vecs[5]  = '{0, 0,  0,    0,   0,  0,  0,       0,       0, 0,  0,    0,  1,  0,                        0};
        vecs[6]  = '{1, 0,  5555, 0,   0,  0,  0,       0,       0, 0,  0,    0,  1,  0,                        0};
        vecs[7]  = '{0, 0,  0,    0,   0,  0,  0,       0,       0, 0,  0,    0,  1,  0,                        0};
        vecs[8]  = '{1, 10, 7777, 1,   0,  0,  0,       0,       0, 0,  0,    0,  1,  0,                        0};
        vecs[9]  = '{1, 11, 2021, 1,   10, 0,  0,       0,       0, 10, 7777, 1,  1,  BYP ? 32'd7777 : 32'd0,   0};
        vecs[10] = '{1, 11, 2022, 1,   11, 10, 0,       0,       0, 10, 7777, 2,  1,  BYP ? 32'd2021 : 32'd0,   BYP ? 32'd7777 : 32'd0};
        vecs[11] = '{0, 0,  0,    1,   10, 11, 0,       0,       0, 10, 7777, 3,  1,  BYP ? 32'd7777 : 32'd0,   BYP ? 32'd2022 : 32'd0};
        vecs[12] = '{0, 0,  0,    0,   0,  0,  0,       0,       1, 10, 7777, 3,  1,  0,                        0};
        vecs[13] = '{0, 0,  0,    0,   11, 10, 0,       32'h55,  1, 11, 2021, 2,  1,  BYP ? 32'd2022 : 32'd0,   32'h55};
        vecs[14] = '{0, 0,  0,    0,   0,  0,  0,       0,       1, 11, 2022, 1,  1,  0,                        0};
        vecs[15] = '{0, 0,  0,    0,   0,  0,  0,       0,       0, 0,  0,    0,  1,  0,                        0};

        // Reset state.
        rst     = 1'b0;
        rf_hold = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_level", 32'(level), 0);
        check("reset_we", 32'(writeEnable), 0);
        check("reset_ready", 32'(push_ready), 1);
        rst = 1'b1;
        @(negedge clk);

        // Table: back-to-back drain, rd==0 discard, held forwarding, drain.
        for (int i = 0; i < 16; i++) begin
            push_valid = vecs[i].pv;
            push_rd    = vecs[i].prd;
            push_data  = vecs[i].pdata;
            rf_hold    = vecs[i].hold;
            rs         = vecs[i].rs;
            rt         = vecs[i].rt;
            rf_regA    = vecs[i].ra;
            rf_regB    = vecs[i].rb;
            #1;
            check($sformatf("v%0d_we", i),    32'(writeEnable), 32'(vecs[i].e_we));
            check($sformatf("v%0d_rd", i),    32'(rd),          32'(vecs[i].e_rd));
            check($sformatf("v%0d_din", i),   din,              vecs[i].e_din);
            check($sformatf("v%0d_level", i), 32'(level),       32'(vecs[i].e_level));
            check($sformatf("v%0d_ready", i), 32'(push_ready),  32'(vecs[i].e_ready));
            check($sformatf("v%0d_regA", i),  regA,             vecs[i].e_rega);
            check($sformatf("v%0d_regB", i),  regB,             vecs[i].e_regb);
            @(negedge clk);
        end
        idle_inputs();

        // Held queue fills to 4; fifth push refused; release drains exactly four in order.
        rf_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1;
            push_rd    = 5'(3 + i);
            push_data  = 32'(100 + i);
            #1;
            check($sformatf("fill%0d_level", i), 32'(level), (i < 4) ? 32'(i) : 32'd4);
            check($sformatf("fill%0d_ready", i), 32'(push_ready), (i < 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        push_valid = 1'b0;
        #1;
        check("full_level", 32'(level), 4);
        check("full_ready", 32'(push_ready), 0);
        check("full_held_we", 32'(writeEnable), 0);
        @(negedge clk);
        rf_hold = 1'b0;
        nw = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (writeEnable) begin
                check($sformatf("drain%0d_rd", nw), 32'(rd), 32'(3 + nw));
                check($sformatf("drain%0d_din", nw), din, 32'(100 + nw));
                nw++;
            end
            @(negedge clk);
        end
        check("drain_count", 32'(nw), 4);
        check("drain_level", 32'(level), 0);

        // Full queue with pop: push refused this cycle, accepted the next.
        rf_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1;
            push_rd    = 5'(1 + i);
            push_data  = 32'(10 + i);
            @(negedge clk);
        end
        rf_hold    = 1'b0;
        push_valid = 1'b1;
        push_rd    = 5'd9;
        push_data  = 32'd99;
        #1;
        check("fp_a_level", 32'(level), 4);
        check("fp_a_ready", 32'(push_ready), 0);
        check("fp_a_we", 32'(writeEnable), 1);
        check("fp_a_rd", 32'(rd), 1);
        @(negedge clk);
        #1;
        check("fp_b_level", 32'(level), 3);
        check("fp_b_ready", 32'(push_ready), 1);
        check("fp_b_rd", 32'(rd), 2);
        @(negedge clk);
        push_valid = 1'b0;
        #1;
        check("fp_c_level", 32'(level), 3);
        check("fp_c_rd", 32'(rd), 3);
        @(negedge clk);
        #1;
        check("fp_d_rd", 32'(rd), 4);
        @(negedge clk);
        #1;
        check("fp_e_rd", 32'(rd), 9);
        check("fp_e_din", din, 99);
        check("fp_e_level", 32'(level), 1);
        @(negedge clk);
        #1;
        check("fp_f_level", 32'(level), 0);
        @(negedge clk);

        // Asynchronous reset mid-queue discards entries; no writes after release.
        rf_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1;
            push_rd    = 5'(20 + i);
            push_data  = 32'(200 + i);
            @(negedge clk);
        end
        push_valid = 1'b0;
        #1;
        check("rst_pre_level", 32'(level), 3);
        rf_hold = 1'b0;
        rst     = 1'b0;
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_we", 32'(writeEnable), 0);
        check("rst_din", din, 0);
        check("rst_rd", 32'(rd), 0);
        check("rst_ready", 32'(push_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("post_rst%0d_we", c), 32'(writeEnable), 0);
            check($sformatf("post_rst%0d_level", c), 32'(level), 0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write entries, power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 push_valid  input  1  producer offers one register write this cycle.
REQ-005 push_ready  output  1  queue can accept a push this cycle.
REQ-006 push_rd  input  5  destination register index of the offered write.
REQ-007 push_data  input  32  data of the offered write.
REQ-008 rf_hold  input  1  register-file write port unavailable; suppresses draining.
REQ-009 din  output  32  write data to register file.
REQ-010 rd  output  5  write index to register file.
REQ-011 writeEnable  output  1  write strobe to register file.
REQ-012 rs, rt  input  5 each  read indices presented to register file.
REQ-013 rf_regA, rf_regB  input  32 each  raw read data returned by register file.
REQ-014 regA, regB  output  32 each  read data after queue forwarding.
REQ-015 level  output  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-016 Queue SHALL be in-order FIFO, circular head/tail pointers wrapping at DEPTH, count register.
REQ-017 push_ready SHALL equal (level < DEPTH), combinational from count only.
REQ-018 Push accepted on rising edge when push_valid && push_ready; push while !push_ready ignored, no state change.
REQ-019 Accepted push with push_rd == 0 SHALL be discarded (not enqueued, level unchanged).
REQ-020 writeEnable SHALL equal (level != 0) && !rf_hold; din/rd SHALL show head entry when level != 0, else 0.
REQ-021 Pop SHALL occur on rising edge when writeEnable is 1, i.e. same edge on which register file captures din.
REQ-022 Latency: entry pushed at edge N into empty queue drives writeEnable during cycle after N, written at edge N+1.
REQ-023 Simultaneous push and pop SHALL leave level unchanged; full queue SHALL NOT accept a push even when popping that cycle.
REQ-024 Entries SHALL drain in push order, one per unheld cycle; rf_hold high SHALL freeze head, level unaffected except by pushes.
REQ-025 Forwarding: regA = data of youngest valid entry whose rd == rs, else rf_regA; regB likewise for rt; rs/rt == 0 SHALL always select rf value.
REQ-026 Forwarding SHALL be combinational, consider only entries valid at start of cycle (not the pushing entry).

Reset
REQ-027 rst low SHALL immediately clear head, tail, count: level=0, writeEnable=0, din=0, rd=0, push_ready=1.
REQ-028 Reset mid-drain SHALL discard all pending entries; no writeEnable pulse during or on release of reset.
REQ-029 Entry data storage need not be reset; valid state derives from count only.

Configuration
REQ-030 Macro WBQ_BYPASS_EN defined: forwarding per REQ-025/026 compiled in.
REQ-031 WBQ_BYPASS_EN undefined: regA = rf_regA, regB = rf_regB, no comparators synthesized; all other behaviour identical.

Verification
REQ-032 rf_hold=0, push (1,1234),(2,6666),(10,7777),(11,2021) back-to-back -> writeEnable high 4 consecutive cycles starting cycle after first push, rd 1,2,10,11, din 1234,6666,7777,2021; level returns 0.
REQ-033 rf_hold=1, push 5 entries -> push_ready low after 4th, level=4, 5th not enqueued; release hold -> exactly 4 writes, in order.
REQ-034 WBQ_BYPASS_EN defined, hold=1, queue (10,7777),(11,2021),(11,2022), rs=10, rt=11, rf_regA=rf_regB=0 -> regA=7777, regB=2022; without macro -> regA=regB=0.
REQ-035 Push (0,5555) into empty queue -> level stays 0, writeEnable stays 0; rs=0 with rf_regA=0 -> regA=0.
REQ-036 Full queue, hold=0, push_valid=1 -> no acceptance that cycle, level 4->3 after pop, push accepted next cycle (level 3 held).
REQ-037 level=3, hold=1, assert rst low between edges -> level, writeEnable, din, rd all 0 before next edge; after release, no writes occur.
